sdsu_bus_slave: RTL and testbench

SDSU_BUS_SLAVE -- requirements
Module: sdsu_bus_slave

---
 rtl/sdsu_bus_pkg.sv | 16 +
 rtl/shift_add_mul.sv | 49 ++++
 rtl/sdsu_bus_slave.sv | 117 +++++++++++
 tb/tb_sdsu_bus_slave.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/sdsu_bus_pkg.sv
// Shared constants and types for the sdsu_bus_slave multiplier peripheral.
package sdsu_bus_pkg;

   localparam int unsigned OP_W_DEFAULT = 16;

   localparam logic [31:0] ADDR_CTRL = 32'd0;
   localparam logic [31:0] ADDR_OPA  = 32'd1;
   localparam logic [31:0] ADDR_OPB  = 32'd2;

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      DONE
   } state_e;

endpackage

// File: rtl/shift_add_mul.sv
// Sequential shift-add unsigned multiplier, one multiplier bit per step, LSB first.
module shift_add_mul #(
   parameter int unsigned OP_W = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load_i,
   input  logic [OP_W-1:0]   opa_i,
   input  logic [OP_W-1:0]   opb_i,
   input  logic              step_i,
   output logic [2*OP_W-1:0] product_o
);

   logic [2*OP_W-1:0] mcand_q, mcand_d;
   logic [OP_W-1:0]   mplier_q, mplier_d;
   logic [2*OP_W-1:0] acc_q, acc_d;

   always_comb begin
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      acc_d    = acc_q;
      if (load_i) begin
         mcand_d  = {{OP_W{1'b0}}, opa_i};
         mplier_d = opb_i;
         acc_d    = '0;
      end else if (step_i) begin
         if (mplier_q[0]) begin
            acc_d = acc_q + mcand_q;
         end
         mcand_d  = mcand_q << 1;
         mplier_d = mplier_q >> 1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mcand_q  <= '0;
         mplier_q <= '0;
         acc_q    <= '0;
      end else begin
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         acc_q    <= acc_d;
      end
   end

   assign product_o = acc_q;

endmodule

// File: rtl/sdsu_bus_slave.sv
// Bus-mapped multiplier: register decode, trigger detection and BUSY/DONE sequencing.
module sdsu_bus_slave
   import sdsu_bus_pkg::*;
#(
   parameter int unsigned OP_W   = OP_W_DEFAULT,
   parameter int unsigned CYCLES = OP_W
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        valid,
   input  logic        exec,
   input  logic        write,
   input  logic [31:0] address,
   input  logic [31:0] data,
   input  logic        start,
   output logic        ready,
   output logic [31:0] result_data,
   output logic        busy
);

   localparam int unsigned CntW = (CYCLES > 1) ? $clog2(CYCLES) : 1;

   state_e             state_q, state_d;
   logic [CntW-1:0]    cnt_q, cnt_d;
   logic [31:0]        opa_q, opa_d;
   logic [31:0]        opb_q, opb_d;
   logic [31:0]        result_q, result_d;
   logic               ready_q, ready_d;
   logic               start_q;
   logic               wr_acc, trigger;
   logic               mul_load, mul_step;
   logic [2*OP_W-1:0]  product;
   logic               unused_op_hi;

   assign wr_acc  = valid & exec & write;
   // CTRL write and a start edge in the same cycle collapse into one trigger
   assign trigger = (wr_acc && (address == ADDR_CTRL) && data[0]) || (start && !start_q);

   always_comb begin
      opa_d = opa_q;
      opb_d = opb_q;
      if (wr_acc && (address == ADDR_OPA)) opa_d = data;
      if (wr_acc && (address == ADDR_OPB)) opb_d = data;
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      ready_d  = 1'b0;
      result_d = result_q;
      mul_load = 1'b0;
      mul_step = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (trigger) begin
               state_d  = BUSY;
               cnt_d    = '0;
               mul_load = 1'b1;
            end
         end
         BUSY: begin
            mul_step = 1'b1;
            if (cnt_q == CntW'(CYCLES - 1)) begin
               state_d = DONE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         DONE: begin
            state_d  = IDLE;
            ready_d  = 1'b1;
            result_d = 32'(product);
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         opa_q    <= '0;
         opb_q    <= '0;
         result_q <= '0;
         ready_q  <= 1'b0;
         start_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         opa_q    <= opa_d;
         opb_q    <= opb_d;
         result_q <= result_d;
         ready_q  <= ready_d;
         start_q  <= start;
      end
   end

   shift_add_mul #(
      .OP_W (OP_W)
   ) u_mul (
      .clk       (clk),
      .rst       (rst),
      .load_i    (mul_load),
      .opa_i     (opa_q[OP_W-1:0]),
      .opb_i     (opb_q[OP_W-1:0]),
      .step_i    (mul_step),
      .product_o (product)
   );

   // Upper operand bits are stored but never reach the multiplier
   assign unused_op_hi = ^{opa_q, opb_q};

   assign ready       = ready_q;
   assign result_data = result_q;
   assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_sdsu_bus_slave.sv
// Self-checking bench: operand/result vector table plus hand-built corner sequences.
module tb_sdsu_bus_slave;
   import sdsu_bus_pkg::*;

   localparam int unsigned OP_W   = 16;
   localparam int unsigned CYCLES = OP_W;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        valid = 1'b0, exec = 1'b0, write = 1'b0, start = 1'b0;
   logic [31:0] address = '0, data = '0;
   logic        ready, busy;
   logic [31:0] result_data;

   sdsu_bus_slave #(
      .OP_W   (OP_W),
      .CYCLES (CYCLES)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .valid       (valid),
      .exec        (exec),
      .write       (write),
      .address     (address),
      .data        (data),
      .start       (start),
      .ready       (ready),
      .result_data (result_data),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [31:0] res;
      int unsigned at;
   } exp_t;
   exp_t sb[$];

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      bit          use_start;
      logic [31:0] res;
   } vec_t;
   vec_t tbl[7];

   int n_vec  = 0;
   int n_fail = 0;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      n_vec++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got %h, want %h", name, got, want);
      end
   endtask

   // Scoreboard side: every ready pulse must match the oldest pending trigger
   always @(negedge clk) begin
      exp_t e;
      if (!rst && ready === 1'b1) begin
         if (sb.size() == 0) begin
            n_vec++;
            n_fail++;
            $display("FAIL spurious_ready: got ready=1 at cycle %0d, want 0", cyc);
         end else begin
            e = sb.pop_front();
            chk("result", result_data, e.res);
            chk("latency", cyc, e.at);
         end
      end
   end

   task automatic wr(input logic [31:0] a, input logic [31:0] d);
      valid = 1'b1; exec = 1'b1; write = 1'b1; address = a; data = d;
      @(posedge clk); #1;
      valid = 1'b0; exec = 1'b0; write = 1'b0;
   endtask

   task automatic trig_start();
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   // Called #1 after the trigger edge, so cyc holds that edge's number
   task automatic expect_op(input logic [31:0] res);
      exp_t e;
      e.res = res;
      e.at  = cyc + CYCLES + 1;
      sb.push_back(e);
   endtask

   task automatic drain(input string name);
      int i = 0;
      while (sb.size() != 0 && i < 4 * CYCLES + 10) begin
         @(posedge clk); #1;
         i++;
      end
      chk(name, sb.size(), 0);
      sb.delete();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      tbl[0] = '{a: 32'd3,          b: 32'd5,      use_start: 1'b0, res: 32'd15};
      tbl[1] = '{a: 32'h0000_FFFF,  b: 32'hFFFF,   use_start: 1'b1, res: 32'hFFFE_0001};
      tbl[2] = '{a: 32'hFFFF_8003,  b: 32'd2,      use_start: 1'b0, res: 32'h0001_0006};
      tbl[3] = '{a: 32'd0,          b: 32'h1234,   use_start: 1'b0, res: 32'd0};
      tbl[4] = '{a: 32'd1,          b: 32'hFFFF,   use_start: 1'b1, res: 32'h0000_FFFF};
      tbl[5] = '{a: 32'h8000,       b: 32'd2,      use_start: 1'b0, res: 32'h0001_0000};
      tbl[6] = '{a: 32'hAB,         b: 32'hABCD_00CD, use_start: 1'b1, res: 32'h0000_88EF};

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      chk("rst_ready", {31'd0, ready}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_result", result_data, 32'd0);
      rst = 1'b0;
      @(posedge clk); #1;

      for (int i = 0; i < 7; i++) begin
         wr(ADDR_OPA, tbl[i].a);
         wr(ADDR_OPB, tbl[i].b);
         if (tbl[i].use_start) trig_start();
         else wr(ADDR_CTRL, 32'd1);
         expect_op(tbl[i].res);
         chk("busy_after_trig", {31'd0, busy}, 32'd1);
         drain("vec_done");
         chk("busy_idle", {31'd0, busy}, 32'd0);
         chk("result_hold", result_data, tbl[i].res);
      end

      // Retrigger and operand write mid-BUSY: one pulse, original operands
      wr(ADDR_OPA, 32'd6);
      wr(ADDR_OPB, 32'd7);
      wr(ADDR_CTRL, 32'd1);
      expect_op(32'd42);
      wr(ADDR_CTRL, 32'd1);
      wr(ADDR_OPA, 32'd7);
      trig_start();
      drain("midbusy_done");
      wr(ADDR_CTRL, 32'd1);
      expect_op(32'd49);
      drain("midbusy_next");

      // Start edge and CTRL write in the same cycle count as one trigger
      start = 1'b1;
      wr(ADDR_CTRL, 32'd1);
      start = 1'b0;
      expect_op(32'd49);
      drain("dual_trig");

      // Ignored addresses, CTRL bit0=0, and unqualified transfers
      wr(ADDR_OPA, 32'd4);
      wr(ADDR_OPB, 32'd5);
      wr(32'd3, 32'd9);
      wr(32'hFFFF_FFFF, 32'd9);
      wr(ADDR_CTRL, 32'd0);
      wr(ADDR_CTRL, 32'd2);
      valid = 1'b1; exec = 1'b0; write = 1'b1; address = ADDR_CTRL; data = 32'd1;
      @(posedge clk); #1;
      exec = 1'b1; write = 1'b0;
      @(posedge clk); #1;
      valid = 1'b0; exec = 1'b0;
      chk("ignored_busy", {31'd0, busy}, 32'd0);
      repeat (CYCLES + 3) @(posedge clk);
      #1;
      chk("ignored_result", result_data, 32'd49);
      wr(ADDR_CTRL, 32'd1);
      expect_op(32'd20);
      drain("ignored_next");

      // Reset 5 cycles into BUSY aborts the operation
      wr(ADDR_OPA, 32'd9);
      wr(ADDR_OPB, 32'd9);
      wr(ADDR_CTRL, 32'd1);
      repeat (5) @(posedge clk);
      #1;
      chk("abort_busy_pre", {31'd0, busy}, 32'd1);
      rst = 1'b1;
      #1;
      chk("abort_busy", {31'd0, busy}, 32'd0);
      chk("abort_ready", {31'd0, ready}, 32'd0);
      chk("abort_result", result_data, 32'd0);
      repeat (2) @(posedge clk);
      #1;
      // First edge after release honours a start edge; operands were cleared
      rst = 1'b0;
      trig_start();
      expect_op(32'd0);
      chk("post_rst_busy", {31'd0, busy}, 32'd1);
      drain("post_rst_done");
      repeat (2 * CYCLES) @(posedge clk);
      #1;
      chk("final_busy", {31'd0, busy}, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
